// File: rtl/frame_regs_pkg.sv
// Shared register-map constants for the fixed-frame CPU register bus.
// Imported by both the write-register block and the read-back block.
package frame_regs_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_HEAD   = 9'd200;
  localparam logic [ADDR_W-1:0] ADDR_FLAG   = 9'd201;
  localparam logic [ADDR_W-1:0] ADDR_LEN    = 9'd202;
  localparam logic [ADDR_W-1:0] ADDR_SCR    = 9'd203;
  localparam logic [ADDR_W-1:0] ADDR_OKCNT  = 9'd204;
  localparam logic [ADDR_W-1:0] ADDR_ERRCNT = 9'd205;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 9'd206;
  localparam logic [ADDR_W-1:0] ADDR_VER    = 9'd207;

  localparam int unsigned ST_W       = 4;
  localparam int unsigned ST_ERR     = 0;
  localparam int unsigned ST_OVF     = 1;
  localparam int unsigned ST_OK_SAT  = 2;
  localparam int unsigned ST_ERR_SAT = 3;

  localparam logic [DATA_W-1:0] VERSION_DEFAULT = 32'h5344_0001;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with clear; a clear coinciding with an event loads 1.
// sat_hit flags an event arriving while the counter is already full.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         pRST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat_hit
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic full;

  assign full    = (cnt == CNT_MAX);
  assign sat_hit = inc & full;

  always_ff @(posedge clk or posedge pRST) begin
    if (pRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && !full) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/load_read.sv
// CPU read-back of frame configuration plus clear-on-read frame counters
// and sticky status flags.
module load_read
  import frame_regs_pkg::*;
#(
  parameter int unsigned      OK_CNT_W  = 32,
  parameter int unsigned      ERR_CNT_W = 16,
  parameter logic [31:0]      VERSION   = VERSION_DEFAULT
) (
  input  logic              clk,
  input  logic              pRST,
  input  logic              cpu_rd_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic [31:0]       packet_head,
  input  logic [15:0]       flag_set,
  input  logic [23:0]       length_set,
  input  logic              scramble,
  input  logic              error,
  input  logic              frame_ok,
  input  logic              frame_err,
  input  logic              fifo_ovf
);

  logic                 rd_n_d;
  logic                 rd_evt;
  logic                 clr_ok;
  logic                 clr_err;
  logic                 clr_status;
  logic [OK_CNT_W-1:0]  ok_cnt;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 ok_sat_hit;
  logic                 err_sat_hit;
  logic [ST_W-1:0]      status_q;
  logic [ST_W-1:0]      status_d;
  logic [DATA_W-1:0]    rdata_mux;

  // One read event per low period of the strobe.
  always_ff @(posedge clk or posedge pRST) begin
    if (pRST) rd_n_d <= 1'b1;
    else      rd_n_d <= cpu_rd_n;
  end

  assign rd_evt     = rd_n_d & ~cpu_rd_n;
  assign clr_ok     = rd_evt & (cpu_addr == ADDR_OKCNT);
  assign clr_err    = rd_evt & (cpu_addr == ADDR_ERRCNT);
  assign clr_status = rd_evt & (cpu_addr == ADDR_STATUS);

  sat_counter #(.W(OK_CNT_W)) u_ok_cnt (
    .clk     (clk),
    .pRST    (pRST),
    .inc     (frame_ok),
    .clr     (clr_ok),
    .cnt     (ok_cnt),
    .sat_hit (ok_sat_hit)
  );

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk     (clk),
    .pRST    (pRST),
    .inc     (frame_err),
    .clr     (clr_err),
    .cnt     (err_cnt),
    .sat_hit (err_sat_hit)
  );

  // Sticky flags: a set in the same cycle as a clear wins.
  always_comb begin
    status_d             = status_q;
    if (clr_status) status_d = '0;
    if (error)       status_d[ST_ERR]     = 1'b1;
    if (fifo_ovf)    status_d[ST_OVF]     = 1'b1;
    if (ok_sat_hit)  status_d[ST_OK_SAT]  = 1'b1;
    if (err_sat_hit) status_d[ST_ERR_SAT] = 1'b1;
  end

  always_ff @(posedge clk or posedge pRST) begin
    if (pRST) status_q <= '0;
    else      status_q <= status_d;
  end

  always_comb begin
    rdata_mux = '0;
    case (cpu_addr)
      ADDR_HEAD:   rdata_mux = packet_head;
      ADDR_FLAG:   rdata_mux = {16'h0, flag_set};
      ADDR_LEN:    rdata_mux = {8'h0, length_set};
      ADDR_SCR:    rdata_mux = {31'h0, scramble};
      ADDR_OKCNT:  rdata_mux = DATA_W'(ok_cnt);
      ADDR_ERRCNT: rdata_mux = DATA_W'(err_cnt);
      ADDR_STATUS: rdata_mux = DATA_W'(status_q);
      ADDR_VER:    rdata_mux = VERSION;
      default:     rdata_mux = '0;
    endcase
  end

  // Snapshot taken on the event cycle, before any clear lands.
  always_ff @(posedge clk or posedge pRST) begin
    if (pRST) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= rd_evt;
      if (rd_evt) cpu_rdata <= rdata_mux;
    end
  end

endmodule

// File: tb/tb_load_read.sv
// Directed and randomized bench for load_read against a counting reference model.
module tb_load_read;

  localparam int unsigned OK_W  = 32;
  localparam int unsigned ERR_W = 4;
  localparam longint      OK_MAX  = (64'd1 << OK_W) - 1;
  localparam longint      ERR_MAX = (64'd1 << ERR_W) - 1;

  logic        clk = 1'b0;
  logic        pRST;
  logic        cpu_rd_n;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic [31:0] packet_head;
  logic [15:0] flag_set;
  logic [23:0] length_set;
  logic        scramble;
  logic        error;
  logic        frame_ok;
  logic        frame_err;
  logic        fifo_ovf;

  int checks = 0;
  int errors = 0;

  // reference model state
  longint      m_ok, m_err;
  bit          ms_err, ms_ovf, ms_oksat, ms_errsat;
  bit          m_rdn_d;
  bit          m_rvalid;
  logic [31:0] m_rdata;

  load_read #(.OK_CNT_W(OK_W), .ERR_CNT_W(ERR_W), .VERSION(32'h5344_0001)) dut (
    .clk         (clk),
    .pRST        (pRST),
    .cpu_rd_n    (cpu_rd_n),
    .cpu_addr    (cpu_addr),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .packet_head (packet_head),
    .flag_set    (flag_set),
    .length_set  (length_set),
    .scramble    (scramble),
    .error       (error),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .fifo_ovf    (fifo_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lookup(input logic [8:0] a);
    case (int'(a))
      200: return packet_head;
      201: return {16'h0, flag_set};
      202: return {8'h0, length_set};
      203: return {31'h0, scramble};
      204: return 32'(m_ok);
      205: return 32'(m_err);
      206: return {28'h0, ms_errsat, ms_oksat, ms_ovf, ms_err};
      207: return 32'h5344_0001;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ok = 0; m_err = 0;
    ms_err = 0; ms_ovf = 0; ms_oksat = 0; ms_errsat = 0;
    m_rdn_d = 1; m_rvalid = 0; m_rdata = '0;
  endtask

  task automatic model_edge();
    bit evt, c_ok, c_err, c_st;
    if (pRST) begin
      model_reset();
      return;
    end
    evt  = !cpu_rd_n && m_rdn_d;
    c_ok  = evt && (cpu_addr == 9'd204);
    c_err = evt && (cpu_addr == 9'd205);
    c_st  = evt && (cpu_addr == 9'd206);
    m_rvalid = evt;
    if (evt) m_rdata = lookup(cpu_addr);
    if (frame_ok && m_ok == OK_MAX)   ms_oksat = 1;  else if (c_st) ms_oksat = 0;
    if (frame_err && m_err == ERR_MAX) ms_errsat = 1; else if (c_st) ms_errsat = 0;
    if (error)    ms_err = 1; else if (c_st) ms_err = 0;
    if (fifo_ovf) ms_ovf = 1; else if (c_st) ms_ovf = 0;
    if (c_ok) m_ok = frame_ok ? 1 : 0;
    else if (frame_ok && m_ok < OK_MAX) m_ok++;
    if (c_err) m_err = frame_err ? 1 : 0;
    else if (frame_err && m_err < ERR_MAX) m_err++;
    m_rdn_d = cpu_rd_n;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("rvalid", 32'(cpu_rvalid), 32'(m_rvalid));
    chk("rdata", cpu_rdata, m_rdata);
  endtask

  task automatic rd(input logic [8:0] a, output logic [31:0] d);
    cpu_addr = a;
    cpu_rd_n = 1'b0;
    step();
    d = cpu_rdata;
    cpu_rd_n = 1'b1;
    step();
  endtask

  task automatic pulse_ok(input int n);
    repeat (n) begin frame_ok = 1'b1; step(); frame_ok = 1'b0; end
  endtask

  task automatic pulse_err(input int n);
    repeat (n) begin frame_err = 1'b1; step(); frame_err = 1'b0; end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp_map [8];
    int          nvalid;

    pRST = 1'b1; cpu_rd_n = 1'b1; cpu_addr = '0;
    packet_head = 32'hA5A5_0001; flag_set = 16'h1234; length_set = 24'h00_0800;
    scramble = 1'b1; error = 1'b0; frame_ok = 1'b0; frame_err = 1'b0; fifo_ovf = 1'b0;
    model_reset();
    #1;
    chk("reset_rdata", cpu_rdata, 32'h0);
    chk("reset_rvalid", 32'(cpu_rvalid), 32'h0);
    repeat (2) step();
    pRST = 1'b0;
    step();

    // register map
    exp_map = '{32'hA5A5_0001, 32'h0000_1234, 32'h0000_0800, 32'h1,
                32'h0, 32'h0, 32'h0, 32'h5344_0001};
    for (int i = 0; i < 8; i++) begin
      rd(9'(200 + i), d);
      chk($sformatf("map_%0d", 200 + i), d, exp_map[i]);
    end
    rd(9'd199, d); chk("unmapped_199", d, 32'h0);
    rd(9'd208, d); chk("unmapped_208", d, 32'h0);

    // ok counter clear-on-read
    pulse_ok(5);
    rd(9'd204, d); chk("ok_cnt_5", d, 32'd5);
    rd(9'd204, d); chk("ok_cnt_clr", d, 32'd0);

    // long low strobe gives a single access
    pulse_err(3);
    cpu_addr = 9'd205; cpu_rd_n = 1'b0; nvalid = 0;
    repeat (10) begin
      step();
      if (cpu_rvalid) begin nvalid++; d = cpu_rdata; end
    end
    cpu_rd_n = 1'b1; step();
    if (cpu_rvalid) nvalid++;
    chk("hold_nvalid", 32'(nvalid), 32'd1);
    chk("hold_err_cnt", d, 32'd3);
    rd(9'd205, d); chk("hold_err_cleared", d, 32'd0);

    // err counter saturation
    pulse_err(17);
    rd(9'd205, d); chk("err_sat_cnt", d, 32'd15);
    rd(9'd206, d); chk("err_sat_status", d, 32'h8);
    rd(9'd206, d); chk("err_sat_status_clr", d, 32'h0);

    // event coincident with clear
    pulse_ok(7);
    cpu_addr = 9'd204; cpu_rd_n = 1'b0; frame_ok = 1'b1;
    step();
    frame_ok = 1'b0; d = cpu_rdata; cpu_rd_n = 1'b1;
    step();
    chk("ok_same_cycle", d, 32'd7);
    rd(9'd204, d); chk("ok_same_cycle_next", d, 32'd1);

    // sticky error / overflow
    error = 1'b1; step(); error = 1'b0;
    fifo_ovf = 1'b1; step(); fifo_ovf = 1'b0;
    rd(9'd206, d); chk("sticky_3", d, 32'h3);
    rd(9'd206, d); chk("sticky_clr", d, 32'h0);

    // reset in the middle of an access
    error = 1'b1; step(); error = 1'b0;
    fifo_ovf = 1'b1; step(); fifo_ovf = 1'b0;
    pulse_ok(2); pulse_err(2);
    cpu_addr = 9'd206; cpu_rd_n = 1'b0;
    #2; pRST = 1'b1; #1;
    model_reset();
    chk("abort_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("abort_rdata", cpu_rdata, 32'h0);
    repeat (2) step();
    pRST = 1'b0;
    step();
    chk("post_rst_event", 32'(cpu_rvalid), 32'h1);
    chk("post_rst_status", cpu_rdata, 32'h0);
    cpu_rd_n = 1'b1; step();
    rd(9'd204, d); chk("post_rst_ok", d, 32'h0);
    rd(9'd205, d); chk("post_rst_err", d, 32'h0);
    rd(9'd206, d); chk("post_rst_st", d, 32'h0);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      frame_ok  = ($urandom_range(0, 3) == 0);
      frame_err = ($urandom_range(0, 2) == 0);
      fifo_ovf  = ($urandom_range(0, 15) == 0);
      error     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) begin
        packet_head = $urandom();
        flag_set    = 16'($urandom());
        length_set  = 24'($urandom());
        scramble    = 1'($urandom());
      end
      if (!cpu_rd_n) begin
        if ($urandom_range(0, 2) != 0) cpu_rd_n = 1'b1;
      end else if ($urandom_range(0, 1) == 0) begin
        cpu_addr = 9'($urandom_range(196, 210));
        cpu_rd_n = 1'b0;
      end
      step();
    end
    frame_ok = 1'b0; frame_err = 1'b0; fifo_ovf = 1'b0; error = 1'b0;
    cpu_rd_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
